// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine driving a single-port S-array RAM.
// Optional S[k]=k fill, then the KSA swap loop for any key length, size and read latency.
module rc4_ksa_engine #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned KEY_BYTES = 3,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic [KEY_BYTES*8-1:0] secret_key,
  input  logic                   do_init,
  input  logic                   start,
  input  logic [7:0]             mem_rdata,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [7:0]             mem_wdata,
  output logic                   mem_we,
  output logic                   ready,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned KEY_W  = KEY_BYTES * 8;
  localparam int unsigned KIDX_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam int unsigned CNT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [ADDR_W-1:0] I_LAST   = '1;
  localparam logic [KIDX_W-1:0] K_LAST   = KIDX_W'(KEY_BYTES - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RD_LAT - 1);

  localparam logic [3:0] IDLE    = 4'd0;
  localparam logic [3:0] INIT_WR = 4'd1;
  localparam logic [3:0] RD_I    = 4'd2;
  localparam logic [3:0] WAIT_I  = 4'd3;
  localparam logic [3:0] CALC_J  = 4'd4;
  localparam logic [3:0] RD_J    = 4'd5;
  localparam logic [3:0] WAIT_J  = 4'd6;
  localparam logic [3:0] WR_I    = 4'd7;
  localparam logic [3:0] WR_J    = 4'd8;
  localparam logic [3:0] DONE    = 4'd9;

  logic [3:0]        state_q, state_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [ADDR_W-1:0] j_q, j_d;
  logic [KIDX_W-1:0] kidx_q, kidx_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [7:0]        si_q, si_d;
  logic [7:0]        sj_q, sj_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [7:0]        key_byte_c;
  logic [ADDR_W-1:0] j_next_c;
  logic              adv_c;

  // Key byte 0 is the most significant byte of the latched key
  always_comb begin
    key_byte_c = '0;
    for (int k = 0; k < int'(KEY_BYTES); k++) begin
      if (kidx_q == KIDX_W'(k)) key_byte_c = key_q[KEY_W-1-8*k -: 8];
    end
  end

  assign j_next_c = j_q + si_q[ADDR_W-1:0] + key_byte_c[ADDR_W-1:0];

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      kidx_q  <= '0;
      key_q   <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      kidx_q  <= kidx_d;
      key_q   <= key_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    kidx_d  = kidx_q;
    key_d   = key_q;
    si_d    = si_q;
    sj_d    = sj_q;
    cnt_d   = cnt_q;
    adv_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = secret_key;
          i_d     = '0;
          j_d     = '0;
          kidx_d  = '0;
          cnt_d   = '0;
          state_d = do_init ? INIT_WR : RD_I;
        end
      end
      INIT_WR: begin
        i_d = i_q + ADDR_W'(1);
        if (i_q == I_LAST) state_d = RD_I;
      end
      RD_I: begin
        cnt_d   = '0;
        state_d = WAIT_I;
      end
      WAIT_I: begin
        if (cnt_q == CNT_LAST) begin
          si_d    = mem_rdata;
          cnt_d   = '0;
          state_d = CALC_J;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CALC_J: begin
        j_d = j_next_c;
        if (j_next_c == i_q) adv_c = 1'b1;
        else                 state_d = RD_J;
      end
      RD_J: begin
        cnt_d   = '0;
        state_d = WAIT_J;
      end
      WAIT_J: begin
        if (cnt_q == CNT_LAST) begin
          sj_d    = mem_rdata;
          cnt_d   = '0;
          state_d = WR_I;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WR_I: state_d = WR_J;
      WR_J: adv_c = 1'b1;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Iteration advance, shared by the skip and swap paths
    if (adv_c) begin
      if (i_q == I_LAST) begin
        state_d = DONE;
      end else begin
        i_d     = i_q + ADDR_W'(1);
        kidx_d  = (kidx_q == K_LAST) ? '0 : kidx_q + KIDX_W'(1);
        state_d = RD_I;
      end
    end
  end

  // Moore output decode
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    ready     = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
      end
      INIT_WR: begin
        mem_addr  = i_q;
        mem_wdata = 8'(i_q);
        mem_we    = 1'b1;
      end
      RD_I, WAIT_I, CALC_J: mem_addr = i_q;
      RD_J, WAIT_J:         mem_addr = j_q;
      WR_I: begin
        mem_addr  = i_q;
        mem_wdata = sj_q;
        mem_we    = 1'b1;
      end
      WR_J: begin
        mem_addr  = j_q;
        mem_wdata = si_q;
        mem_we    = 1'b1;
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// Bench for rc4_ksa_engine: four parameter sets, each with its own RAM, driver and cycle-exact
// comparison against a software KSA that emits the expected per-cycle RAM traffic.
module tb_rc4_ksa_engine;

  localparam int NCFG  = 4;
  localparam int EVMAX = 4096;

  typedef struct {
    int addr;
    int we;
    int wd;
    bit busy;
    bit done;
    bit rdy;
  } exp_t;

  int n_cmp = 0;
  int n_bad = 0;
  bit fin[NCFG];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 30) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic int key_byte(logic [255:0] key, int kb, int idx);
    return int'(key[(kb - 1 - (idx % kb)) * 8 +: 8]);
  endfunction

  function automatic exp_t rec(int a, int w, int d, bit b, bit dn, bit r);
    exp_t e;
    e = '{a, w, d, b, dn, r};
    return e;
  endfunction

  // Software KSA emitting one expected record per cycle after start acceptance
  function automatic int build(input int n, input int lat, input int kb, input logic [255:0] key,
                               input bit init, inout int s[256], output exp_t ev[EVMAX],
                               output int swaps, output int skips, output bit skipped[256]);
    int c;
    int j;
    int t;
    c = 0; j = 0; swaps = 0; skips = 0;
    for (int k = 0; k < 256; k++) skipped[k] = 1'b0;
    if (init) begin
      for (int k = 0; k < n; k++) begin
        s[k] = k;
        ev[c] = rec(k, 1, k, 1, 0, 0); c++;
      end
    end
    for (int i = 0; i < n; i++) begin
      ev[c] = rec(i, 0, -1, 1, 0, 0); c++;
      for (int w = 0; w < lat; w++) begin ev[c] = rec(-1, 0, -1, 1, 0, 0); c++; end
      j = (j + s[i] + key_byte(key, kb, i)) % n;
      ev[c] = rec(-1, 0, -1, 1, 0, 0); c++;
      if (j == i) begin
        skips++;
        skipped[i] = 1'b1;
      end else begin
        ev[c] = rec(j, 0, -1, 1, 0, 0); c++;
        for (int w = 0; w < lat; w++) begin ev[c] = rec(-1, 0, -1, 1, 0, 0); c++; end
        ev[c] = rec(i, 1, s[j], 1, 0, 0); c++;
        ev[c] = rec(j, 1, s[i], 1, 0, 0); c++;
        t = s[i]; s[i] = s[j]; s[j] = t;
        swaps++;
      end
    end
    ev[c] = rec(-1, 0, -1, 0, 1, 0); c++;
    ev[c] = rec(-1, 0, -1, 0, 0, 1); c++;
    return c;
  endfunction

  // Hand-computed pins on the model itself
  int   ps[256];
  exp_t pev[EVMAX];
  int   psw, psk, pn;
  bit   pskd[256];

  initial begin : pin_model
    int nwe;
    int fw;
    int kexp[7];
    pn = build(4, 1, 2, 256'h0102, 1'b1, ps, pev, psw, psk, pskd);
    chk("pin_t1_s0", ps[0], 0);
    chk("pin_t1_s1", ps[1], 3);
    chk("pin_t1_s2", ps[2], 2);
    chk("pin_t1_s3", ps[3], 1);
    chk("pin_t1_swaps", psw, 3);
    chk("pin_t1_skip_i2", int'(pskd[2]), 1);
    nwe = 0;
    for (int k = 0; k < pn; k++) nwe += pev[k].we;
    chk("pin_t1_writes", nwe, 10);
    chk("pin_t1_done_cycle_done", int'(pev[28].done), 1);
    chk("pin_t1_len", pn, 30);

    pn = build(256, 1, 3, 256'h0, 1'b1, ps, pev, psw, psk, pskd);
    chk("pin_t2_skip_i0", int'(pskd[0]), 1);
    chk("pin_t2_skip_i1", int'(pskd[1]), 1);
    fw = -1;
    for (int k = pn - 1; k >= 256; k--) if (pev[k].we == 1) fw = k;
    chk("pin_t2_w0_addr", pev[fw].addr, 2);
    chk("pin_t2_w0_data", pev[fw].wd, 3);
    chk("pin_t2_w1_addr", pev[fw+1].addr, 3);
    chk("pin_t2_w1_data", pev[fw+1].wd, 2);

    kexp = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'h01, 8'h23};
    for (int i = 0; i < 7; i++)
      chk($sformatf("pin_t6_keybyte%0d", i), key_byte(256'h0123456789, 5, i), kexp[i]);
  end

  localparam int CA[NCFG] = '{2, 8, 8, 8};
  localparam int CK[NCFG] = '{2, 3, 3, 5};
  localparam int CL[NCFG] = '{1, 1, 3, 2};
  localparam logic [39:0] CKEY[NCFG] = '{40'h0102, 40'h0, 40'h4A2F91, 40'h0123456789};

  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int AW  = CA[g];
    localparam int KB  = CK[g];
    localparam int LAT = CL[g];
    localparam int N   = 1 << AW;

    logic          rst;
    logic [KB*8-1:0] key;
    logic          init, start;
    logic [7:0]    rdata, wdata;
    logic [AW-1:0] addr;
    logic          we, ready, busy, done;

    rc4_ksa_engine #(.ADDR_W(AW), .KEY_BYTES(KB), .RD_LAT(LAT)) dut (
      .CLOCK_50(clk), .reset(rst), .secret_key(key), .do_init(init), .start(start),
      .mem_rdata(rdata), .mem_addr(addr), .mem_wdata(wdata), .mem_we(we),
      .ready(ready), .busy(busy), .done(done));

    logic [7:0] mem[N];
    logic [7:0] pre[N];
    logic [7:0] pipe[LAT];
    bit         load;

    always @(posedge clk) begin
      if (load) for (int k = 0; k < N; k++) mem[k] <= pre[k];
      else if (we) mem[addr] <= wdata;
      pipe[0] <= mem[addr];
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign rdata = pipe[LAT-1];

    exp_t ev[EVMAX];
    exp_t e;
    int   nev, ptr, done_at, swaps, skips;
    int   ms[256];
    bit   skd[256];
    bit   ev_valid, running, run_done;

    always @(negedge clk) begin
      if (rst) begin
        running = 1'b0;
      end else if (running) begin
        e = ev[ptr];
        chk($sformatf("c%0d.we@%0d", g, ptr), int'(we), e.we);
        chk($sformatf("c%0d.busy@%0d", g, ptr), int'(busy), int'(e.busy));
        chk($sformatf("c%0d.done@%0d", g, ptr), int'(done), int'(e.done));
        chk($sformatf("c%0d.ready@%0d", g, ptr), int'(ready), int'(e.rdy));
        if (e.addr >= 0) chk($sformatf("c%0d.addr@%0d", g, ptr), int'(addr), e.addr);
        if (e.we == 1) chk($sformatf("c%0d.wdata@%0d", g, ptr), int'(wdata), e.wd & 255);
        if (e.done) done_at = ptr + 1;
        ptr++;
        if (ptr == nev) begin
          running  = 1'b0;
          run_done = 1'b1;
          ev_valid = 1'b0;
        end
      end else if (ev_valid && ready && start) begin
        running = 1'b1;
        ptr     = 0;
      end
    end

    task automatic run(input logic [39:0] k, input bit di, input bit hold, input bit abort);
      logic [255:0] kk;
      int t;
      int bad;
      kk = '0;
      kk[KB*8-1:0] = k[KB*8-1:0];
      nev = build(N, LAT, KB, kk, di, ms, ev, swaps, skips, skd);
      run_done = 1'b0;
      done_at  = 0;
      ev_valid = 1'b1;
      @(posedge clk); #1;
      key = k[KB*8-1:0]; init = di; start = 1'b1;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      if (abort) begin
        t = 0;
        while (!we && t < 20000) begin @(negedge clk); t++; end
        chk($sformatf("c%0d.abort_wait", g), int'(we), 1);
        #2 rst = 1'b1;
        #1;
        chk($sformatf("c%0d.abort_we", g), int'(we), 0);
        chk($sformatf("c%0d.abort_ready", g), int'(ready), 1);
        chk($sformatf("c%0d.abort_busy", g), int'(busy), 0);
        chk($sformatf("c%0d.abort_addr", g), int'(addr), 0);
        ev_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        return;
      end
      if (hold) begin
        repeat (nev / 2) @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        t = 0;
        while (!done && t < nev + 50) begin @(negedge clk); t++; end
        @(posedge clk); #1 start = 1'b0;
      end
      t = 0;
      while (!run_done && t < nev + 50) begin @(posedge clk); t++; end
      chk($sformatf("c%0d.run_complete", g), int'(run_done), 1);
      chk($sformatf("c%0d.done_cycle", g), done_at,
          (di ? N : 0) + swaps * (5 + 2 * LAT) + skips * (2 + LAT) + 1);
      bad = -1;
      for (int a = N - 1; a >= 0; a--) if (int'(mem[a]) != (ms[a] & 255)) bad = a;
      chk($sformatf("c%0d.ram_first_bad_idx", g), bad, -1);
    endtask

    initial begin : seq
      logic [39:0] rk;
      rst = 1'b0; start = 1'b0; init = 1'b0; key = '0; load = 1'b0;
      ev_valid = 1'b0; running = 1'b0; run_done = 1'b0;
      #1 rst = 1'b1;
      #2;
      chk($sformatf("c%0d.rst_ready", g), int'(ready), 1);
      chk($sformatf("c%0d.rst_busy", g), int'(busy), 0);
      chk($sformatf("c%0d.rst_done", g), int'(done), 0);
      chk($sformatf("c%0d.rst_we", g), int'(we), 0);
      chk($sformatf("c%0d.rst_addr", g), int'(addr), 0);
      chk($sformatf("c%0d.rst_wdata", g), int'(wdata), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      run(CKEY[g], 1'b1, 1'b0, 1'b0);

      for (int k = 0; k < N; k++) begin pre[k] = 8'(k); ms[k] = k; end
      @(posedge clk); #1 load = 1'b1;
      @(posedge clk); #1 load = 1'b0;
      run(40'h4A2F91, 1'b0, 1'b0, 1'b0);

      rk = {8'($urandom), 32'($urandom)};
      run(rk, 1'b0, 1'b1, 1'b0);

      rk = {8'($urandom), 32'($urandom)};
      run(rk, 1'b0, 1'b0, 1'b1);

      rk = {8'($urandom), 32'($urandom)};
      run(rk, 1'b1, 1'b0, 1'b0);
      fin[g] = 1'b1;
    end
  end

  initial begin : summary
    int t;
    t = 0;
    while (t < 90000 && !(fin[0] && fin[1] && fin[2] && fin[3])) begin
      @(posedge clk);
      t++;
    end
    if (!(fin[0] && fin[1] && fin[2] && fin[3])) chk("global_timeout", 0, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rc4_ksa_engine.md
Name: rc4_ksa_engine

Overview:
Parametrised RC4 key-scheduling engine, the successor to the fixed 24-bit-key shuffle FSM. It drives a single-port S-array RAM. It can optionally initialise S[k]=k itself, then runs the KSA swap loop for any key length, array size and RAM read latency. It sits between the key-search controller, which supplies the key and start, and the S-RAM mux. It hands off to the PRGA/decrypt stage through ready/done.

Parameters:
ADDR_W, 8, S-array address width; N = 2**ADDR_W entries; range 2..8
KEY_BYTES, 3, key length in bytes; range 1..32
RD_LAT, 1, cycles from the address cycle to valid mem_rdata; range 1..4

Ports:
CLOCK_50  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-high; all state and outputs return to reset values immediately
secret_key  in  KEY_BYTES*8  key; byte 0 = secret_key[KEY_BYTES*8-1 -: 8] (MSB first); sampled only on start acceptance
do_init  in  1  sampled with start; 1 = write S[k]=k before the KSA loop, 0 = use RAM contents as-is
start  in  1  request; accepted only in IDLE
mem_rdata  in  8  RAM read data
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  8  RAM write data
mem_we  out  1  RAM write enable
ready  out  1  high in IDLE
busy  out  1  high in every state except IDLE and DONE
done  out  1  one-cycle pulse in DONE

Behaviour:
- Reset values: state=IDLE, mem_addr=0, mem_wdata=0, mem_we=0, done=0, busy=0, ready=1. Internal i, j, kidx, key latch and data registers are all cleared.
- Outputs are Moore and are decoded from state plus internal registers. The RAM samples addr/we/wdata on the edge that ends the cycle.
- States: IDLE, INIT_WR, RD_I, WAIT_I, CALC_J, RD_J, WAIT_J, WR_I, WR_J, DONE.
- IDLE: on start=1, latch secret_key and do_init, clear i/j/kidx, and go to INIT_WR if do_init=1, else RD_I. start is ignored in all other states; there is no queueing.
- INIT_WR: mem_addr=i, mem_wdata=i (zero-extended), mem_we=1. One write per cycle. i increments; when i=N-1 is written, i wraps to 0 and the state goes to RD_I. Duration N cycles.
- RD_I: mem_addr=i, 1 cycle. WAIT_I: RD_LAT cycles; S[i] is captured at the edge ending the last WAIT_I cycle.
- CALC_J: j_next = (j + S[i] + key_byte[kidx]) mod N. Both S[i] and the key byte are truncated to ADDR_W. Register j.
  - If j_next == i: skip the swap, so no reads or writes. Apply the iteration advance rule.
  - Otherwise go to RD_J.
- RD_J: mem_addr=j, 1 cycle. WAIT_J: RD_LAT cycles, then capture S[j].
- WR_I: mem_addr=i, mem_wdata=S[j], mem_we=1.
- WR_J: mem_addr=j, mem_wdata=S[i], mem_we=1. Then apply the iteration advance rule.
- Iteration advance:
  - If i==N-1, go to DONE.
  - Otherwise i+1; kidx+1, wrapping to 0 after KEY_BYTES-1 (a counter, not a modulo); go to RD_I.
- DONE: done=1 for one cycle, then IDLE. The engine is restartable without reset.
- Iteration cost: swap = 5+2*RD_LAT cycles; skip = 2+RD_LAT cycles.
- Total cycles from the cycle after start is accepted through DONE: (do_init?N:0) + sum of iterations + 1.
- mem_we=0 in every state except INIT_WR, WR_I and WR_J.
- reset asserted mid-run aborts immediately to reset values. A partially shuffled RAM is left as-is.

Test Plan:
1. ADDR_W=2, KEY_BYTES=2, RD_LAT=1, key=16'h0102, do_init=1, start pulse:
   - Required final RAM [0,3,2,1].
   - Exactly 4 init writes plus 6 swap writes.
   - Iteration i=2 is skipped.
   - done pulses in cycle 29 after start acceptance.
2. Defaults, key=24'h000000, do_init=1:
   - i=0 and i=1 issue no RAM access after their reads.
   - First swap writes are addr 2 data 3, then addr 3 data 2.
   - Final RAM matches the software KSA model.
3. Defaults, RAM preloaded S[k]=k, do_init=0, key=24'h4A2F91:
   - No INIT writes; the first mem_addr after start is 0.
   - Final RAM matches the model.
   - Repeat with RD_LAT=3: identical RAM; cycle count grows per the formula.
4. start held high for the whole run, with a second start pulse mid-run:
   - The pulse is ignored, with exactly one done.
   - ready=0 and busy=1 throughout; ready=1 the cycle after done.
   - A following start with a new key produces the model result.
5. Assert reset asynchronously (between clock edges) during WR_I:
   - Outputs go to reset values before the next edge: mem_we=0, ready=1.
   - A subsequent full run with do_init=1 produces the correct RAM.
6. KEY_BYTES=5, ADDR_W=8, key=40'h0123456789:
   - The key byte used at i=0..6 is 01,23,45,67,89,01,23.
   - Final RAM matches the model.
